// File: rtl/cmd_fifo_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : cmd_fifo_sync
// Brief    : Single-clock FWFT command FIFO (ready/valid push, head-visible pop).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module cmd_fifo_sync #(
   parameter int TYPE_WIDTH = 2,
   parameter int ADDR_WIDTH = 27,
   parameter int BRST_WIDTH = 6,
   parameter int DATA_WIDTH = 128,
   parameter int MASK_WIDTH = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  io_push_valid,
   output logic                  io_push_ready,
   input  logic [TYPE_WIDTH-1:0] io_push_cmd_type,
   input  logic [ADDR_WIDTH-1:0] io_push_addr,
   input  logic [BRST_WIDTH-1:0] io_push_burst_cnt,
   input  logic [DATA_WIDTH-1:0] io_push_wt_data,
   input  logic [MASK_WIDTH-1:0] io_push_wt_mask,
   input  logic                  io_pop_valid,
   output logic                  io_pop_ready,
   output logic [TYPE_WIDTH-1:0] io_pop_cmd_type,
   output logic [ADDR_WIDTH-1:0] io_pop_addr,
   output logic [BRST_WIDTH-1:0] io_pop_burst_cnt,
   output logic [DATA_WIDTH-1:0] io_pop_wt_data,
   output logic [MASK_WIDTH-1:0] io_pop_wt_mask
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int WORD_W = TYPE_WIDTH + ADDR_WIDTH + BRST_WIDTH + DATA_WIDTH + MASK_WIDTH;
   localparam logic [DEPTH_LOG2:0] c_FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] c_ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

   logic [WORD_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;

   logic                  w_not_full;
   logic                  w_not_empty;
   logic                  w_push_fire;
   logic                  w_pop_fire;
   logic [WORD_W-1:0]     w_push_word;
   logic [WORD_W-1:0]     w_head_word;

   // Ready flags depend only on the registered count, never on the valids.
   assign w_not_full  = (r_count != c_FULL_CNT);
   assign w_not_empty = (r_count != '0);

   assign w_push_fire = io_push_valid & w_not_full;
   assign w_pop_fire  = io_pop_valid & w_not_empty;

   assign w_push_word = {io_push_cmd_type, io_push_addr, io_push_burst_cnt,
                         io_push_wt_data, io_push_wt_mask};

   // Storage carries no reset; contents are only observed through rd_ptr when non-empty.
   always_ff @(posedge clk) begin
      if (w_push_fire) begin
         r_mem[r_wr_ptr] <= w_push_word;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_fire) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_fire, w_pop_fire})
            2'b10:   r_count <= r_count + c_ONE_CNT;
            2'b01:   r_count <= r_count - c_ONE_CNT;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head is forced to zero when empty so stale storage never leaks out.
   assign w_head_word = w_not_empty ? r_mem[r_rd_ptr] : '0;

   assign io_push_ready = w_not_full;
   assign io_pop_ready  = w_not_empty;
   assign {io_pop_cmd_type, io_pop_addr, io_pop_burst_cnt,
           io_pop_wt_data, io_pop_wt_mask} = w_head_word;

endmodule
`default_nettype wire

// File: tb/tb_cmd_fifo_sync.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_cmd_fifo_sync
// Brief    : Self-checking bench for cmd_fifo_sync against a queue reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cmd_fifo_sync;

   localparam int W     = 179;
   localparam int DEPTH = 16;

   logic          clk;
   logic          rstn;
   logic          io_push_valid;
   logic          io_push_ready;
   logic [1:0]    io_push_cmd_type;
   logic [26:0]   io_push_addr;
   logic [5:0]    io_push_burst_cnt;
   logic [127:0]  io_push_wt_data;
   logic [15:0]   io_push_wt_mask;
   logic          io_pop_valid;
   logic          io_pop_ready;
   logic [1:0]    io_pop_cmd_type;
   logic [26:0]   io_pop_addr;
   logic [5:0]    io_pop_burst_cnt;
   logic [127:0]  io_pop_wt_data;
   logic [15:0]   io_pop_wt_mask;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] q[$];

   cmd_fifo_sync dut (
      .clk               (clk),
      .rstn              (rstn),
      .io_push_valid     (io_push_valid),
      .io_push_ready     (io_push_ready),
      .io_push_cmd_type  (io_push_cmd_type),
      .io_push_addr      (io_push_addr),
      .io_push_burst_cnt (io_push_burst_cnt),
      .io_push_wt_data   (io_push_wt_data),
      .io_push_wt_mask   (io_push_wt_mask),
      .io_pop_valid      (io_pop_valid),
      .io_pop_ready      (io_pop_ready),
      .io_pop_cmd_type   (io_pop_cmd_type),
      .io_pop_addr       (io_pop_addr),
      .io_pop_burst_cnt  (io_pop_burst_cnt),
      .io_pop_wt_data    (io_pop_wt_data),
      .io_pop_wt_mask    (io_pop_wt_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] beat(input logic [1:0] t, input logic [26:0] a,
                                         input logic [5:0] b, input logic [127:0] d,
                                         input logic [15:0] m);
      return {t, a, b, d, m};
   endfunction

   function automatic logic [W-1:0] rand_beat();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag);
      logic         exp_push_rdy;
      logic         exp_pop_rdy;
      logic [W-1:0] exp_w;
      logic [W-1:0] got_w;
      exp_push_rdy = (q.size() != DEPTH);
      exp_pop_rdy  = (q.size() != 0);
      exp_w        = (q.size() != 0) ? q[0] : '0;
      got_w        = {io_pop_cmd_type, io_pop_addr, io_pop_burst_cnt, io_pop_wt_data, io_pop_wt_mask};
      tests++;
      assert (io_push_ready === exp_push_rdy) else begin
         fails++;
         $error("FAIL %s push_ready observed %b expected %b", tag, io_push_ready, exp_push_rdy);
      end
      tests++;
      assert (io_pop_ready === exp_pop_rdy) else begin
         fails++;
         $error("FAIL %s pop_ready observed %b expected %b", tag, io_pop_ready, exp_pop_rdy);
      end
      tests++;
      assert (got_w === exp_w) else begin
         fails++;
         $error("FAIL %s head observed %h expected %h", tag, got_w, exp_w);
      end
   endtask

   // Drive one cycle, advance the model by the FIFO rules, then check after the edge.
   task automatic cycle(input logic pv, input logic [W-1:0] w, input logic qv, input string tag);
      bit push_fire;
      bit pop_fire;
      io_push_valid = pv;
      {io_push_cmd_type, io_push_addr, io_push_burst_cnt, io_push_wt_data, io_push_wt_mask} = w;
      io_pop_valid  = qv;
      push_fire = pv && (q.size() != DEPTH);
      pop_fire  = qv && (q.size() != 0);
      @(posedge clk);
      #1;
      if (pop_fire)  void'(q.pop_front());
      if (push_fire) q.push_back(w);
      check(tag);
   endtask

   initial begin
      logic [W-1:0]   w;
      logic [127:0]   base;
      base = 128'h0123_4567_890A_BCDE_FEDC_BA98_7654_3210;
      rstn          = 1'b0;
      io_push_valid = 1'b0;
      io_pop_valid  = 1'b0;
      {io_push_cmd_type, io_push_addr, io_push_burst_cnt, io_push_wt_data, io_push_wt_mask} = '0;

      // 1: reset state, released off-edge
      #20;
      check("reset");
      #77 rstn = 1'b1;
      @(posedge clk); #1;
      check("post_reset");

      // 2: burst of 8 with pop held off, then drain
      for (int i = 0; i < 8; i++) begin
         w = beat(2'd2, 27'd0, 6'd7, base + 128'(i), 16'hFFFF << (i + 1));
         cycle(1'b1, w, 1'b0, "burst_push");
      end
      tests++;
      assert (q.size() == 8 && io_pop_wt_data === base) else begin
         fails++;
         $error("FAIL burst_head data observed %h expected %h", io_pop_wt_data, base);
      end
      for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, "burst_pop");

      // 3: fill to full, extra beat rejected, drain 16
      for (int i = 0; i < 17; i++) cycle(1'b1, rand_beat(), 1'b0, "full_push");
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, "full_pop");

      // 4: simultaneous push/pop at count 5 and at full
      for (int i = 0; i < 5; i++) cycle(1'b1, rand_beat(), 1'b0, "sim_fill5");
      for (int i = 0; i < 4; i++) cycle(1'b1, rand_beat(), 1'b1, "sim_at5");
      for (int i = 0; i < 11; i++) cycle(1'b1, rand_beat(), 1'b0, "sim_fill16");
      cycle(1'b1, rand_beat(), 1'b1, "sim_at_full");
      tests++;
      assert (q.size() == 15) else begin
         fails++;
         $error("FAIL sim_full_count observed %0d expected 15", q.size());
      end
      for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, "sim_drain");

      // 5: continuous stream across pointer wrap
      for (int i = 0; i < 40; i++) cycle(1'b1, rand_beat(), 1'b1, "wrap");
      cycle(1'b0, '0, 1'b1, "wrap_drain");

      // 6: async reset after 3 of 8 pushes, then fresh burst
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_beat(), 1'b0, "mid_push");
      #3 rstn = 1'b0;
      #1;
      q.delete();
      check("mid_reset");
      #2 rstn = 1'b1;
      for (int i = 0; i < 8; i++) cycle(1'b1, rand_beat(), 1'b0, "after_push");
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "after_pop");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 99) < 60), rand_beat(), 1'($urandom_range(0, 99) < 50), "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
